// File: rtl/decim_pkg.sv
// Shared types and constants for the decimation scheduler: arbiter states,
// channel-index width helper and default sample/decimation parameters.
package decim_pkg;

  localparam int DEFAULT_DATA_W            = 16;
  localparam int DEFAULT_DOWNSAMPLE_FACTOR = 64;

  typedef enum logic [0:0] {
    ARB_IDLE    = 1'b0,
    ARB_PRESENT = 1'b1
  } arb_state_e;

  // Width of a channel index; never narrower than one bit.
  function automatic int CH_IDX_W(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/decim_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester found searching upward
// (with wrap) from the channel after last_i.
module rr_pick
  import decim_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CW     = CH_IDX_W(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [CW-1:0]     last_i,
  output logic [CW-1:0]     grant_o,
  output logic              any_req_o
);

  // Rotating priority search over all channels.
  always_comb begin
    logic [CW:0] idx;
    logic        found;
    idx     = {(CW+1){1'b0}};
    found   = 1'b0;
    grant_o = {CW{1'b0}};
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = {1'b0, last_i} + (CW+1)'(i);
      if (idx >= (CW+1)'(NUM_CH)) begin
        idx = idx - (CW+1)'(NUM_CH);
      end else begin
        idx = idx;
      end
      if (!found && req_i[idx[CW-1:0]]) begin
        found   = 1'b1;
        grant_o = idx[CW-1:0];
      end else begin
        found   = found;
      end
    end
    any_req_o = |req_i;
  end

endmodule

// File: rtl/decim_arbiter.sv
// Per-channel decimation with one-deep holding registers, multiplexed onto a
// single ready/valid output by a round-robin arbiter.
module decim_arbiter
  import decim_pkg::*;
#(
  parameter int NUM_CH            = 4,
  parameter int DOWNSAMPLE_FACTOR = DEFAULT_DOWNSAMPLE_FACTOR,
  parameter int DATA_W            = DEFAULT_DATA_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic [NUM_CH-1:0]          ch_valid,
  input  logic [NUM_CH*DATA_W-1:0]   ch_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(NUM_CH)-1:0]  out_ch,
  output logic [NUM_CH-1:0]          overflow,
  input  logic                       clr_overflow
);

  localparam int CW = CH_IDX_W(NUM_CH);
  localparam int PW = (DOWNSAMPLE_FACTOR > 1) ? $clog2(DOWNSAMPLE_FACTOR) : 1;

  logic [NUM_CH-1:0] capture_s;
  logic [NUM_CH-1:0] deq_s;
  logic [NUM_CH-1:0] ovf_set_s;
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [NUM_CH-1:0] overflow_q, overflow_d;
  logic [DATA_W-1:0] hold_s [NUM_CH];

  arb_state_e        state_q, state_d;
  logic [CW-1:0]     last_grant_q;
  logic [CW-1:0]     grant_s;
  logic              any_req_s;
  logic              load_s;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic [CW-1:0]     out_ch_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [PW-1:0]     phase_q;
    logic [DATA_W-1:0] hold_q;

    assign capture_s[c] = ch_valid[c] & enable & (phase_q == {PW{1'b0}});
    assign deq_s[c]     = load_s & (grant_s == CW'(c));
    // A capture only drops when the slot is occupied and not draining this edge.
    assign ovf_set_s[c] = capture_s[c] & pending_q[c] & ~deq_s[c];
    assign hold_s[c]    = hold_q;

    // Decimation phase; power-of-two factor wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        phase_q <= {PW{1'b0}};
      end else if (!enable) begin
        phase_q <= {PW{1'b0}};
      end else if (ch_valid[c]) begin
        phase_q <= phase_q + PW'(1);
      end
    end

    // Holding register loads on every non-dropped capture.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hold_q <= {DATA_W{1'b0}};
      end else if (capture_s[c] && !ovf_set_s[c]) begin
        hold_q <= ch_data[c*DATA_W +: DATA_W];
      end
    end
  end

  assign pending_d  = (pending_q & ~deq_s) | (capture_s & ~ovf_set_s);
  assign overflow_d = clr_overflow ? ovf_set_s : (overflow_q | ovf_set_s);

  rr_pick #(
    .NUM_CH (NUM_CH),
    .CW     (CW)
  ) u_pick (
    .req_i     (pending_q),
    .last_i    (last_grant_q),
    .grant_o   (grant_s),
    .any_req_o (any_req_s)
  );

  // Arbiter next state and output-register load strobe.
  always_comb begin
    state_d = state_q;
    load_s  = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (any_req_s) begin
          load_s  = 1'b1;
          state_d = ARB_PRESENT;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_PRESENT: begin
        if (out_ready && any_req_s) begin
          load_s  = 1'b1;
          state_d = ARB_PRESENT;
        end else if (out_ready) begin
          state_d = ARB_IDLE;
        end else begin
          state_d = ARB_PRESENT;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // Arbiter state, shared flags and the registered output port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB_IDLE;
      pending_q    <= {NUM_CH{1'b0}};
      overflow_q   <= {NUM_CH{1'b0}};
      last_grant_q <= CW'(NUM_CH - 1);
      out_valid_q  <= 1'b0;
      out_data_q   <= {DATA_W{1'b0}};
      out_ch_q     <= {CW{1'b0}};
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      overflow_q  <= overflow_d;
      out_valid_q <= (state_d == ARB_PRESENT);
      if (load_s) begin
        out_data_q   <= hold_s[grant_s];
        out_ch_q     <= grant_s;
        last_grant_q <= grant_s;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign overflow  = overflow_q;

endmodule
